// File: rtl/i2c_cmd_arbiter.sv
// Two-requester arbiter for a single I2C phy command port.
// Ownership spans a whole transaction (start .. stop). Read data and errors
// are routed only to the owner, and a watchdog turns a hung transaction into
// a forced stop.
module i2c_cmd_arbiter #(
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       A_STB,
   input  logic [2:0] A_MODE,
   input  logic [7:0] A_DATA,
   output logic       A_ACK,
   output logic       A_VAL,
   output logic [7:0] A_RDATA,
   output logic       A_ERR,
   input  logic       B_STB,
   input  logic [2:0] B_MODE,
   input  logic [7:0] B_DATA,
   output logic       B_ACK,
   output logic       B_VAL,
   output logic [7:0] B_RDATA,
   output logic       B_ERR,
   output logic       P_STB,
   output logic [2:0] P_MODE,
   output logic [7:0] P_DATA,
   input  logic       P_ACK,
   input  logic       P_VAL,
   input  logic [7:0] P_RDATA,
   input  logic       P_ERR,
   output logic [1:0] GNT,
   output logic       TOUT
);

   typedef enum logic [2:0] {IDLE, OWN_A, OWN_B, ABORT, RELEASE} state_t;

   // Counter value at which the next cycle would reach TIMEOUT.
   localparam logic [31:0] LIMIT = 32'(TIMEOUT - 1);

   state_t      state;
   logic [1:0]  gnt_q;
   logic        last_b;     // 1: B owned the most recent transaction
   logic [31:0] cnt;
   logic        rej_a, rej_b;
   logic        terr_a, terr_b;
   logic        tout_q;

   logic cand_a, cand_b, bad_a, bad_b, fwd_stop, cnt_exp;

   assign cand_a   = A_STB && (A_MODE == 3'd0);
   assign cand_b   = B_STB && (B_MODE == 3'd0);
   assign bad_a    = A_STB && (A_MODE != 3'd0);
   assign bad_b    = B_STB && (B_MODE != 3'd0);
   assign fwd_stop = P_STB && (P_MODE == 3'd7);
   assign cnt_exp  = (cnt == LIMIT);

   // Phy command mux: the owner's command passes straight through; ABORT injects a stop.
   always_comb begin
      P_STB  = 1'b0;
      P_MODE = 3'd0;
      P_DATA = 8'h00;
      case (state)
         OWN_A: begin
            P_STB  = A_STB;
            P_MODE = A_MODE;
            P_DATA = A_DATA;
         end
         OWN_B: begin
            P_STB  = B_STB;
            P_MODE = B_MODE;
            P_DATA = B_DATA;
         end
         ABORT: begin
            P_STB  = 1'b1;
            P_MODE = 3'd7;
            P_DATA = 8'h00;
         end
         default: ;
      endcase
   end

   // Acks reach a requester only while it owns the phy (or as a reject pulse in IDLE).
   assign A_ACK   = rej_a | ((state == OWN_A) & P_ACK);
   assign B_ACK   = rej_b | ((state == OWN_B) & P_ACK);
   assign A_VAL   = gnt_q[0] & P_VAL;
   assign B_VAL   = gnt_q[1] & P_VAL;
   assign A_RDATA = gnt_q[0] ? P_RDATA : 8'h00;
   assign B_RDATA = gnt_q[1] ? P_RDATA : 8'h00;
   assign A_ERR   = rej_a | terr_a | (gnt_q[0] & P_ERR);
   assign B_ERR   = rej_b | terr_b | (gnt_q[1] & P_ERR);
   assign GNT     = gnt_q;
   assign TOUT    = tout_q;

   // Ownership FSM with round-robin tie break, reject pulses and watchdog.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         gnt_q  <= 2'b00;
         last_b <= 1'b1;
         cnt    <= '0;
         rej_a  <= 1'b0;
         rej_b  <= 1'b0;
         terr_a <= 1'b0;
         terr_b <= 1'b0;
         tout_q <= 1'b0;
      end else begin
         rej_a  <= 1'b0;
         rej_b  <= 1'b0;
         terr_a <= 1'b0;
         terr_b <= 1'b0;
         tout_q <= 1'b0;
         case (state)
            IDLE: begin
               // A command other than start is refused once; the requester
               // drops its strobe on the ack so it is not refused twice.
               rej_a <= bad_a && !rej_a;
               rej_b <= bad_b && !rej_b;
               cnt   <= '0;
               if (cand_a && (!cand_b || last_b)) begin
                  state <= OWN_A;
                  gnt_q <= 2'b01;
               end else if (cand_b) begin
                  state <= OWN_B;
                  gnt_q <= 2'b10;
               end
            end
            OWN_A, OWN_B: begin
               // A phy ack beats a coincident watchdog expiry.
               if (P_ACK) begin
                  cnt <= '0;
                  if (fwd_stop) begin
                     state  <= RELEASE;
                     gnt_q  <= 2'b00;
                     last_b <= (state == OWN_B);
                  end
               end else if (cnt_exp) begin
                  state  <= ABORT;
                  cnt    <= '0;
                  tout_q <= 1'b1;
                  terr_a <= (state == OWN_A);
                  terr_b <= (state == OWN_B);
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ABORT: begin
               if (P_ACK || cnt_exp) begin
                  state  <= RELEASE;
                  gnt_q  <= 2'b00;
                  last_b <= gnt_q[1];
                  cnt    <= '0;
                  tout_q <= !P_ACK;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
